// File: rtl/cv32e40x_pkg.sv
// Shared register-file types used by the writeback buffer and its queue.
package cv32e40x_pkg;

  localparam int unsigned REGFILE_ADDR_WIDTH = 5;
  localparam int unsigned REGFILE_WORD_WIDTH = 32;

  typedef logic [REGFILE_ADDR_WIDTH-1:0] rf_addr_t;

  // One register-file write request: destination and data.
  typedef struct packed {
    rf_addr_t                      waddr;
    logic [REGFILE_WORD_WIDTH-1:0] wdata;
  } wb_req_t;

  // x0 is hardwired to zero; writes to it never reach the register file.
  function automatic logic is_x0(rf_addr_t addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/cv32e40x_wb_fifo.sv
// Side-result queue: power-of-two FIFO with wrap-bit pointers and
// per-entry address/valid outputs for operand hazard comparison.
module cv32e40x_wb_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  wb_req_t  push_data_i,
  input  logic     pop_i,
  output wb_req_t  head_o,
  output logic     full_o,
  output logic     empty_o,
  output rf_addr_t entry_addr_o  [DEPTH],
  output logic     entry_valid_o [DEPTH]
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_req_t          mem_q [DEPTH];

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;

  assign widx = wptr_q[IDX_W-1:0];
  assign ridx = rptr_q[IDX_W-1:0];

  // Full when the wrap bits differ and the index bits match.
  assign full_o  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[ridx];

  // Next pointers and entry valid bits; push and pop never share a slot.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    if (push_i) begin
      wptr_d        = wptr_q + PTR_W'(1);
      valid_d[widx] = 1'b1;
    end
    if (pop_i) begin
      rptr_d        = rptr_q + PTR_W'(1);
      valid_d[ridx] = 1'b0;
    end
  end

  // Pointer and valid state; reset discards every entry in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[widx] <= push_data_i;
    end
  end

  // Expose each slot's destination for the pending-write compare.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      entry_addr_o[e]  = mem_q[e].waddr;
      entry_valid_o[e] = valid_q[e];
    end
  end

endmodule

// File: rtl/cv32e40x_rf_wb_buffer.sv
// Register-file write port 0 arbiter: pipeline writeback has absolute
// priority, side results (coprocessor / late load) wait in a FIFO.
module cv32e40x_rf_wb_buffer
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid_i,
  input  rf_addr_t                      wb_waddr_i,
  input  logic [REGFILE_WORD_WIDTH-1:0] wb_wdata_i,
  input  logic                          xr_valid_i,
  output logic                          xr_ready_o,
  input  rf_addr_t                      xr_waddr_i,
  input  logic [REGFILE_WORD_WIDTH-1:0] xr_wdata_i,
  output logic                          rf_we_o,
  output rf_addr_t                      rf_waddr_o,
  output logic [REGFILE_WORD_WIDTH-1:0] rf_wdata_o,
  input  rf_addr_t                      pend_raddr_i [2],
  output logic                          pend_hit_o   [2],
  output logic                          empty_o
);

  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  wb_req_t  fifo_head;
  wb_req_t  xr_req;
  rf_addr_t entry_addr  [DEPTH];
  logic     entry_valid [DEPTH];

  logic                          rf_we_q,    rf_we_d;
  rf_addr_t                      rf_waddr_q, rf_waddr_d;
  logic [REGFILE_WORD_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  assign xr_req.waddr = xr_waddr_i;
  assign xr_req.wdata = xr_wdata_i;

  // Ready depends only on registered occupancy, so a same-cycle pop
  // does not open a slot until the following cycle.
  assign xr_ready_o = !fifo_full;
  assign fifo_push  = xr_valid_i && !fifo_full;
  assign fifo_pop   = !wb_valid_i && !fifo_empty;

  cv32e40x_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (fifo_push),
    .push_data_i   (xr_req),
    .pop_i         (fifo_pop),
    .head_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_addr_o  (entry_addr),
    .entry_valid_o (entry_valid)
  );

  // Select the source for the next write; x0 is consumed without a write.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_valid_i) begin
      rf_we_d    = !is_x0(wb_waddr_i);
      rf_waddr_d = wb_waddr_i;
      rf_wdata_d = wb_wdata_i;
    end else if (fifo_pop) begin
      rf_we_d    = !is_x0(fifo_head.waddr);
      rf_waddr_d = fifo_head.waddr;
      rf_wdata_d = fifo_head.wdata;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign empty_o    = fifo_empty && !rf_we_q;

  // Flag operands whose register still has a write queued or in flight.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      pend_hit_o[k] = 1'b0;
      if (!is_x0(pend_raddr_i[k])) begin
        if (rf_we_q && (rf_waddr_q == pend_raddr_i[k])) begin
          pend_hit_o[k] = 1'b1;
        end
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (entry_valid[e] && (entry_addr[e] == pend_raddr_i[k])) begin
            pend_hit_o[k] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_rf_wb_buffer.sv
// Randomised and directed checks of the writeback buffer against a
// queue-based reference model.
module tb_cv32e40x_rf_wb_buffer;
  import cv32e40x_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  rf_addr_t    wb_waddr;
  logic [31:0] wb_wdata;
  logic        xr_valid;
  logic        xr_ready;
  rf_addr_t    xr_waddr;
  logic [31:0] xr_wdata;
  logic        rf_we;
  rf_addr_t    rf_waddr;
  logic [31:0] rf_wdata;
  rf_addr_t    pend_raddr [2];
  logic        pend_hit   [2];
  logic        empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending side results in order, plus the rf output.
  wb_req_t     mq[$];
  logic        m_we    = 1'b0;
  rf_addr_t    m_waddr = '0;
  logic [31:0] m_wdata = '0;

  cv32e40x_rf_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid_i   (wb_valid),
    .wb_waddr_i   (wb_waddr),
    .wb_wdata_i   (wb_wdata),
    .xr_valid_i   (xr_valid),
    .xr_ready_o   (xr_ready),
    .xr_waddr_i   (xr_waddr),
    .xr_wdata_i   (xr_wdata),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .pend_raddr_i (pend_raddr),
    .pend_hit_o   (pend_hit),
    .empty_o      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic model_hit(input rf_addr_t a);
    logic hit;
    hit = 1'b0;
    if (a != '0) begin
      if (m_we && m_waddr == a) hit = 1'b1;
      foreach (mq[i]) if (mq[i].waddr == a) hit = 1'b1;
    end
    return hit;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the
  // model across the rising edge, then check the registered write port.
  task automatic cycle(input logic wbv, input rf_addr_t wa, input logic [31:0] wd,
                       input logic xv, input rf_addr_t xa, input logic [31:0] xd,
                       input rf_addr_t r0, input rf_addr_t r1);
    logic    exp_ready;
    wb_req_t e;
    @(negedge clk);
    wb_valid = wbv; wb_waddr = wa; wb_wdata = wd;
    xr_valid = xv;  xr_waddr = xa; xr_wdata = xd;
    pend_raddr[0] = r0; pend_raddr[1] = r1;
    #1;
    exp_ready = (mq.size() < int'(DEPTH));
    check_eq("xr_ready", 32'(xr_ready), 32'(exp_ready));
    check_eq("empty", 32'(empty), 32'((mq.size() == 0) && !m_we));
    check_eq("pend_hit0", 32'(pend_hit[0]), 32'(model_hit(r0)));
    check_eq("pend_hit1", 32'(pend_hit[1]), 32'(model_hit(r1)));
    if (wbv) begin
      m_we = (wa != '0); m_waddr = wa; m_wdata = wd;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = (e.waddr != '0); m_waddr = e.waddr; m_wdata = e.wdata;
    end else begin
      m_we = 1'b0;
    end
    if (xv && exp_ready) begin
      e.waddr = xa; e.wdata = xd;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    check_eq("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      check_eq("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      check_eq("rf_wdata", rf_wdata, m_wdata);
    end
  endtask

  task automatic idle(input int n, input rf_addr_t r0, input rf_addr_t r1);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_waddr = '0; wb_wdata = '0;
    xr_valid = 1'b0; xr_waddr = '0; xr_wdata = '0;
    pend_raddr[0] = 5'd5; pend_raddr[1] = 5'd0;
    #12;
    check_eq("reset_rf_we", 32'(rf_we), 32'd0);
    check_eq("reset_xr_ready", 32'(xr_ready), 32'd1);
    check_eq("reset_empty", 32'(empty), 32'd1);
    check_eq("reset_pend_hit0", 32'(pend_hit[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pipeline write then idle.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, '0);
    check_eq("single_waddr", 32'(rf_waddr), 32'd5);
    check_eq("single_wdata", rf_wdata, 32'hDEADBEEF);
    idle(2, 5'd5, '0);

    // Priority: side result waits behind three pipeline writes.
    cycle(1'b1, 5'd3, 32'h30, 1'b1, 5'd7, 32'h11, 5'd7, 5'd3);
    cycle(1'b1, 5'd3, 32'h31, 1'b0, '0, '0, 5'd7, 5'd3);
    cycle(1'b1, 5'd3, 32'h32, 1'b0, '0, '0, 5'd7, 5'd3);
    idle(3, 5'd7, 5'd3);

    // Full: two side results queued behind a stalled drain, third held off.
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd8, 32'h80, 5'd8, 5'd9);
    cycle(1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 32'h90, 5'd8, 5'd9);
    cycle(1'b1, 5'd1, 32'hA3, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd9);
    cycle(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd8);
    cycle(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd9);
    idle(3, 5'd10, '0);

    // x0 side result is consumed without a write.
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h5, 5'd0, 5'd0);
    idle(3, 5'd0, 5'd0);

    // Reset mid-drain.
    cycle(1'b1, 5'd4, 32'h40, 1'b1, 5'd11, 32'hB0, 5'd11, 5'd12);
    cycle(1'b1, 5'd4, 32'h41, 1'b1, 5'd12, 32'hC0, 5'd11, 5'd12);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd11, 5'd12);
    @(negedge clk);
    wb_valid = 1'b0; xr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("mid_rst_empty", 32'(empty), 32'd1);
    check_eq("mid_rst_xr_ready", 32'(xr_ready), 32'd1);
    check_eq("mid_rst_pend_hit1", 32'(pend_hit[1]), 32'd0);
    mq.delete();
    m_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 5'd11, 5'd12);

    // Wrap: ten back-to-back push/pop pairs.
    for (int i = 0; i < 10; i++)
      cycle(1'b0, '0, '0, 1'b1, rf_addr_t'(i + 13), 32'h1000 + 32'(i), rf_addr_t'(i + 13), rf_addr_t'(i + 12));
    idle(2, '0, '0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 9) < 4), rf_addr_t'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), rf_addr_t'($urandom_range(0, 7)), $urandom,
            rf_addr_t'($urandom_range(0, 7)), rf_addr_t'($urandom_range(0, 7)));
    idle(DEPTH + 2, 5'd1, 5'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
